// File: rtl/snap_capture_sequencer.sv
// rtl/snap_capture_sequencer.sv - sequences one snapshot BRAM capture from a software control word
module snap_capture_sequencer #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  user_clk,
  input  logic                  user_rst,
  input  logic [31:0]           ctrl_word,
  input  logic                  trig,
  input  logic                  din_valid,
  input  logic                  stop,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           status
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]         CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic            arm_q;
  logic            trig_imm_q, ign_valid_q, circ_q;
  logic            done_q, wrapped_q;
  // cnt_q doubles as the write pointer: its low bits are the next address
  logic [CW-1:0]   cnt_q;
  logic            arm_rise, abort, qualified;
  logic            capture_cycle, issue_write, busy;
  logic [31:0]     status_d;
  logic            unused_ctrl;

  assign arm_rise    = ctrl_word[0] & ~arm_q;
  assign abort       = ~ctrl_word[0];
  assign qualified   = din_valid | ign_valid_q;
  assign unused_ctrl = ^ctrl_word[31:4];

  // State register
  always_ff @(posedge user_clk) begin
    if (user_rst) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode; abort outranks trigger and stop
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (arm_rise) state_d = S_ARMED;
      S_ARMED: begin
        if (abort)                    state_d = S_IDLE;
        else if (trig_imm_q || trig)  state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort)                    state_d = S_IDLE;
        else if (circ_q && stop)      state_d = S_DONE;
        else if (!circ_q && qualified && cnt_q[ADDR_WIDTH-1:0] == PTR_LAST)
                                      state_d = S_DONE;
      end
      S_DONE:    if (abort) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output decode: write issue, busy flag and the next status word
  always_comb begin
    capture_cycle = 1'b0;
    busy          = 1'b0;
    status_d      = '0;
    unique case (state_q)
      S_ARMED: begin
        busy          = 1'b1;
        capture_cycle = !abort && (trig_imm_q || trig);
      end
      S_CAPTURE: begin
        busy          = 1'b1;
        capture_cycle = !abort && !(circ_q && stop);
      end
      default: ;
    endcase
    issue_write             = capture_cycle && qualified;
    status_d[31]            = done_q;
    status_d[30]            = busy;
    status_d[29]            = wrapped_q;
    status_d[ADDR_WIDTH:0]  = cnt_q;
  end

  // Datapath: arm edge detect, mode latch, pointer/count, BRAM port and status register
  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      arm_q       <= 1'b1;
      trig_imm_q  <= 1'b0;
      ign_valid_q <= 1'b0;
      circ_q      <= 1'b0;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      cnt_q       <= '0;
      bram_we     <= 1'b0;
      bram_addr   <= '0;
      status      <= '0;
    end else begin
      arm_q   <= ctrl_word[0];
      bram_we <= issue_write;
      status  <= status_d;
      if (issue_write) bram_addr <= cnt_q[ADDR_WIDTH-1:0];

      if (state_q == S_IDLE && arm_rise) begin
        trig_imm_q  <= ctrl_word[1];
        ign_valid_q <= ctrl_word[2];
        circ_q      <= ctrl_word[3];
        cnt_q       <= '0;
        done_q      <= 1'b0;
        wrapped_q   <= 1'b0;
      end else if (issue_write) begin
        if (circ_q) begin
          cnt_q <= {1'b0, cnt_q[ADDR_WIDTH-1:0] + PTR_ONE};
          if (cnt_q[ADDR_WIDTH-1:0] == PTR_LAST) wrapped_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end

      if (state_q == S_CAPTURE && state_d == S_DONE) done_q <= 1'b1;
    end
  end

endmodule

// File: doc/snap_capture_sequencer.md
Name: snap_capture_sequencer

Overview:
- Sequences one snapshot capture buffer, such as the 10GbE RX snap, in the user_clk domain.
- Decodes the software control word written through the ppc2simulink control register.
- Drives the BRAM write-enable and address, and returns a status word for a simulink2ppc status register.
- Supports one-shot and circular capture, with immediate or external trigger.

Parameters:
- ADDR_WIDTH, 11: BRAM address width; buffer depth DEPTH = 2^ADDR_WIDTH; legal range 4..16.

Ports:
- user_clk  in  1  design clock; all logic on the rising edge.
- user_rst  in  1  synchronous, active-high reset.
- ctrl_word  in  32  software control word:
  - bit0 arm.
  - bit1 trig_immediate.
  - bit2 ignore_valid.
  - bit3 circular.
  - bits 31..4 ignored.
- trig  in  1  external capture trigger, level-sampled.
- din_valid  in  1  input sample qualifier.
- stop  in  1  ends a circular capture.
- bram_we  out  1  BRAM write enable, registered.
- bram_addr  out  ADDR_WIDTH  BRAM write address, registered.
- status  out  32  status word:
  - bit31 done.
  - bit30 busy.
  - bit29 wrapped.
  - bits ADDR_WIDTH..0 count.
  - all other bits 0.

Behaviour:
- Reset values:
  - State = IDLE; bram_we = 0; bram_addr = 0.
  - status = 0.
  - Internal arm_q = 1, so software must write arm=0 then arm=1 after reset.
- Qualified sample = din_valid OR ctrl_word[2].
- arm_rise = ctrl_word[0] AND NOT arm_q. arm_q <= ctrl_word[0] every cycle.
- States:
  - IDLE:
    - On arm_rise: go to ARMED; clear count, done and wrapped.
    - busy = 0.
  - ARMED:
    - busy = 1.
    - If ctrl_word[1] = 1, or trig = 1, go to CAPTURE.
    - The trigger cycle itself counts as the first capture cycle: if qualified, its sample is written.
  - CAPTURE:
    - busy = 1.
    - Each qualified cycle issues one write at pointer p, then p increments.
    - One-shot (ctrl_word[3] = 0):
      - count = p.
      - When the write at p = DEPTH-1 issues, go to DONE with count = DEPTH.
    - Circular (ctrl_word[3] = 1):
      - p wraps DEPTH-1 -> 0; wrapped set on the first wrap.
      - count = p mod DEPTH, i.e. the oldest-sample address once wrapped.
      - stop = 1 goes to DONE; the sample in the stop cycle is not written.
      - stop is ignored in one-shot mode and in ARMED.
  - DONE:
    - done = 1; busy = 0.
    - Returns to IDLE when ctrl_word[0] = 0.
    - done, count and wrapped hold until the next arm_rise.
- Abort:
  - ctrl_word[0] = 0 in ARMED or CAPTURE returns to IDLE next cycle.
  - done stays 0 and count holds.
  - Abort has priority over trig and stop in the same cycle.
  - A write qualified in the abort cycle is suppressed.
- Mode bits ctrl_word[1..3] are latched on arm_rise; later changes are ignored until the next arm.
- Write timing:
  - A write issued in cycle t appears as bram_we = 1 and bram_addr = p in cycle t+1.
  - The datapath delays din by one register to align.
  - bram_we is 0 in every cycle without an issued write.
  - bram_addr holds its last value when bram_we = 0.
- status is registered and reflects the state and counters of the previous cycle.
- user_rst mid-capture forces all reset values next cycle; no further writes are issued.

Test Plan:
- One-shot immediate, ADDR_WIDTH=4, ignore_valid=1:
  - Stimulus: write ctrl 0x0, then 0x7.
  - Required: 16 consecutive bram_we pulses, addr 0..15 starting 2 cycles after the arm write; then status = 0x80000010.
- External trigger with gaps, ctrl=0x1:
  - Stimulus: trig pulses at cycle 10; din_valid alternates 1/0 from cycle 10.
  - Required: bram_we at cycles 11, 13, 15…; addr 0, 1, 2…; no writes before cycle 11.
- Circular with stop, ADDR_WIDTH=4, ctrl=0xF:
  - Stimulus: run 20 qualified cycles, then assert stop.
  - Required: addr sequence 0..15, 0..3; status = 0xA0000004 (done, wrapped, count 4); no write on the stop cycle.
- Abort:
  - Stimulus: ctrl=0x7, then ctrl=0x6 after 5 writes, with trig high in the same cycle as the ctrl change.
  - Required: exactly 5 writes; state IDLE; status = 0x00000005.
- Reset behaviour:
  - Stimulus: hold ctrl=0x7 through reset release.
  - Required: no arming and status = 0 until ctrl goes to 0 and back to 0x7.
  - Stimulus: user_rst in mid-capture.
  - Required: bram_we = 0 from the next cycle onward.
- Re-arm:
  - Stimulus: after DONE, write ctrl 0x0 then 0x7.
  - Required: done clears on the arm edge; busy goes to 1; the capture restarts at addr 0.
